blink_host_adapter: RTL and testbench
=====================================

Name: blink_host_adapter

Overview:
- Host-side end of the Blink 128-bit tweakable cipher wrapper interface.
- Collects K0 (1024b), K1 (510b), P (128b) and T (128b) as 32-bit addressed register writes, then drives them in parallel to the cipher core with the enc mode bit.
- Waits a fixed core latency, captures C, and returns it as four 32-bit words over a valid/ready stream.
- Sits between a narrow control bus and the wide-port cipher wrapper.

Parameters:
- LATENCY, 16: clock cycles from launch until core_C is valid; must be ≥1.
- DW, 32: host data word width; fixed, not to be overridden.

Ports:
- clk  input  1  single clock, all logic rising-edge.
- rst  input  1  asynchronous, active-low reset.
- wr_en  input  1  register write strobe.
- wr_addr  input  6  word address 0..55.
- wr_data  input  32  write data.
- start  input  1  one-cycle launch pulse.
- start_enc  input  1  mode sampled with start: 1 = encrypt, 0 = decrypt.
- busy  output  1  high from accepted start until last C word accepted.
- err  output  1  sticky protocol-error flag; cleared only by reset.
- out_valid  output  1  C word available.
- out_ready  input  1  host accepts C word.
- out_data  output  32  C word.
- core_enc  output  1  mode to core.
- core_K0  output  1024  key 0 to core.
- core_K1  output  510  key 1 to core.
- core_P  output  128  plaintext/ciphertext to core.
- core_T  output  128  tweak to core.
- core_C  input  128  core result.

Behaviour:
- Reset (rst=0, async): all registers 0, including K0/K1/P/T/enc, counter and output holding register. State=IDLE; busy=0, err=0, out_valid=0, out_data=0.
- Address map, word i holds bits [32i+31:32i] of its field:
  - K0 at 0..31.
  - K1 at 32..47; word 47 bits [31:30] are discarded.
  - P at 48..51.
  - T at 52..55.
  - Addresses 56..63: write ignored, err set.
- Writes:
  - Accepted in IDLE only; take effect the next cycle.
  - wr_en in RUN or OUT: ignored, err set.
  - Operand registers drive core_* continuously; they hold their value after a run, so partial updates are allowed.
- Start and write in the same IDLE cycle: the write lands first, start samples the updated registers, i.e. the core sees the new value from the first RUN cycle.
- FSM:
  - IDLE: on start, latch start_enc into core_enc, cnt=0, go to RUN; busy=1 from the next cycle.
  - RUN: cnt increments each cycle. When cnt==LATENCY-1, capture core_C into the hold register and go to OUT with out_valid=1 and out_data=C[31:0].
  - OUT: on out_valid&&out_ready, advance to the next word (C[63:32], C[95:64], C[127:96]). After the 4th handshake go to IDLE; busy=0 and out_valid=0 next cycle.
  - start in RUN or OUT: ignored, err set.
- Stream rules:
  - out_data is stable while out_valid=1 and out_ready=0.
  - Back-to-back acceptance gives one word per cycle.
- Latency: start accepted at cycle t gives first out_valid at t+LATENCY+1.
- Reset mid-run: state, counter and operand registers return to reset values immediately; no partial output.

Test Plan:
- Write K0 words 0..31 = i, K1 = 0xFFFFFFFF ×16, P = {0x33333333,0x22222222,0x11111111,0x00000000} (word 51..48), T = 0, start enc=1:
  - core_K1 = all-ones over 510 bits.
  - core_P = 128'h33333333_22222222_11111111_00000000.
  - core_enc = 1.
  - out_valid rises exactly LATENCY+1 cycles after start.
- Core model returns C = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, out_ready held 1 → out_data AAAAAAAA, BBBBBBBB, CCCCCCCC, DDDDDDDD on consecutive cycles; busy drops the cycle after the last word.
- out_ready toggled 1,0,0,1,0,1,1 → exactly 4 handshakes, out_data stable across stalls, no words lost or repeated.
- During RUN: issue wr_en to addr 48 with 0xDEADBEEF and a second start → core_P unchanged, err=1, run completes normally.
- Write to addr 60 in IDLE → err=1, no operand change.
- Assert rst=0 mid-RUN at cnt=5 → busy=0, out_valid=0, core_K0=0 immediately. Restart after release → full LATENCY wait observed.

Source files
------------

// File: rtl/blink_host_adapter.sv
// rtl/blink_host_adapter.sv - register-loaded launcher for the Blink cipher core, streaming C back as 32-bit words
module blink_host_adapter #(
  parameter int LATENCY = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [5:0]    wr_addr,
  input  logic [31:0]   wr_data,
  input  logic          start,
  input  logic          start_enc,
  output logic          busy,
  output logic          err,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_data,
  output logic          core_enc,
  output logic [1023:0] core_K0,
  output logic [509:0]  core_K1,
  output logic [127:0]  core_P,
  output logic [127:0]  core_T,
  input  logic [127:0]  core_C
);

  localparam int DW = 32;
  localparam int CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt;
  logic [1:0]      widx;
  logic [127:0]    hold;
  logic            wr_ok;
  logic            last_cnt;
  logic            take;

  assign wr_ok    = wr_en && (state == IDLE) && (wr_addr < 6'd56);
  assign last_cnt = (cnt == CW'(LATENCY - 1));
  assign take     = (state == OUT) && out_ready;

  assign busy      = (state != IDLE);
  assign out_valid = (state == OUT);
  assign out_data  = out_valid ? hold[{widx, 5'd0} +: DW] : '0;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last_cnt) state_nx = OUT;
      OUT:     if (take && (widx == 2'd3)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_K0  <= '0;
      core_K1  <= '0;
      core_P   <= '0;
      core_T   <= '0;
      core_enc <= 1'b0;
      cnt      <= '0;
      widx     <= '0;
      hold     <= '0;
      err      <= 1'b0;
    end else begin
      if (wr_ok) begin
        if (wr_addr < 6'd32) begin
          core_K0[{wr_addr[4:0], 5'd0} +: DW] <= wr_data;
        end else if (wr_addr < 6'd48) begin
          // K1 is 510 bits wide, so the top word only keeps 30 bits
          for (int i = 0; i < 15; i++)
            if (wr_addr[3:0] == 4'(i)) core_K1[i*DW +: DW] <= wr_data;
          if (wr_addr[3:0] == 4'd15) core_K1[509:480] <= wr_data[29:0];
        end else if (wr_addr < 6'd52) begin
          core_P[{wr_addr[1:0], 5'd0} +: DW] <= wr_data;
        end else begin
          core_T[{wr_addr[1:0], 5'd0} +: DW] <= wr_data;
        end
      end

      if ((state == IDLE) && start) begin
        core_enc <= start_enc;
        cnt      <= '0;
      end

      if (state == RUN) begin
        cnt <= cnt + CW'(1);
        if (last_cnt) begin
          hold <= core_C;
          widx <= 2'd0;
        end
      end

      if (take) widx <= widx + 2'd1;

      if ((wr_en && ((state != IDLE) || (wr_addr >= 6'd56))) ||
          (start && (state != IDLE)))
        err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_blink_host_adapter.sv
// tb/tb_blink_host_adapter.sv - scoreboard bench for blink_host_adapter
module tb_blink_host_adapter;

  localparam int L = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic [5:0]    wr_addr = '0;
  logic [31:0]   wr_data = '0;
  logic          start = 1'b0;
  logic          start_enc = 1'b0;
  logic          busy, err, out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_data;
  logic          core_enc;
  logic [1023:0] core_K0;
  logic [509:0]  core_K1;
  logic [127:0]  core_P, core_T, core_C;

  logic [127:0]  c_base = '0;
  logic [127:0]  p_m = '0;
  logic [127:0]  t_m = '0;
  logic [31:0]   sb[$];
  int            checks = 0;
  int            errors = 0;
  int            lat;

  // core stand-in: result depends on operands and mode so stale captures show up
  assign core_C = c_base ^ core_P ^ core_T ^ {128{~core_enc}};

  blink_host_adapter #(.LATENCY(L)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .start_enc(start_enc), .busy(busy), .err(err),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .core_enc(core_enc), .core_K0(core_K0), .core_K1(core_K1),
    .core_P(core_P), .core_T(core_T), .core_C(core_C)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    if (a >= 6'd48 && a < 6'd52) p_m[(a-48)*32 +: 32] = d;
    else if (a >= 6'd52 && a < 6'd56) t_m[(a-52)*32 +: 32] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic push_exp(input logic enc);
    logic [127:0] e;
    e = c_base ^ p_m ^ t_m ^ {128{~enc}};
    for (int i = 0; i < 4; i++) sb.push_back(e[i*32 +: 32]);
  endtask

  task automatic launch(input logic enc, input bit disturb, input bit wr_same, output int n);
    @(negedge clk);
    start = 1'b1; start_enc = enc;
    if (wr_same) begin
      wr_en = 1'b1; wr_addr = 6'd48; wr_data = 32'h0BADF00D;
      p_m[31:0] = 32'h0BADF00D;
    end
    push_exp(enc);
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0; n = 1;
    while (!out_valid && n < 100) begin
      if (disturb && n == 3) begin
        wr_en = 1'b1; wr_addr = 6'd48; wr_data = 32'hDEADBEEF; start = 1'b1;
      end else begin
        wr_en = 1'b0; start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    wr_en = 1'b0; start = 1'b0;
  endtask

  task automatic drain(input logic [15:0] pat, input int plen);
    int hs = 0;
    int k = 0;
    int cyc = 0;
    logic [31:0] prev = '0;
    logic [31:0] e;
    bit stalled = 0;
    while (hs < 4 && cyc < 60) begin
      out_ready = pat[k % plen];
      k++;
      #1;
      if (out_valid) begin
        if (stalled) check("stall_hold", out_data, prev);
        if (out_ready) begin
          if (sb.size() == 0) check("sb_empty", out_data, 'x);
          else begin
            e = sb.pop_front();
            check("c_word", out_data, e);
          end
          hs++;
          stalled = 0;
        end else begin
          stalled = 1;
          prev = out_data;
        end
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    check("handshakes", hs, 4);
    #1;
    check("busy_after", busy, 0);
    check("valid_after", out_valid, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_k0", core_K0[127:0], 0);
    rst = 1'b1;

    for (int i = 0; i < 32; i++) wr(6'(i), 32'(i));
    for (int i = 32; i < 48; i++) wr(6'(i), 32'hFFFFFFFF);
    wr(6'd48, 32'h00000000); wr(6'd49, 32'h11111111);
    wr(6'd50, 32'h22222222); wr(6'd51, 32'h33333333);
    for (int i = 52; i < 56; i++) wr(6'(i), 32'h0);
    for (int i = 0; i < 32; i++) check("k0_word", core_K0[i*32 +: 32], i);
    check("k1_ones", core_K1 == {510{1'b1}}, 1);
    check("p_val", core_P, 128'h33333333_22222222_11111111_00000000);
    c_base = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA ^ p_m;

    launch(1'b1, 0, 0, lat);
    check("latency1", lat, L + 1);
    check("enc1", core_enc, 1);
    void'(sb.pop_front()); void'(sb.pop_front()); void'(sb.pop_front()); void'(sb.pop_front());
    sb.push_back(32'hAAAAAAAA); sb.push_back(32'hBBBBBBBB);
    sb.push_back(32'hCCCCCCCC); sb.push_back(32'hDDDDDDDD);
    drain(16'h7F, 1);
    check("err_clean", err, 0);

    wr(6'd52, 32'h12345678);
    launch(1'b0, 0, 0, lat);
    check("latency2", lat, L + 1);
    check("enc0", core_enc, 0);
    drain(16'b1101001, 7);

    wr(6'd60, 32'hCAFEBABE);
    check("err_addr", err, 1);
    check("p_keep", core_P, p_m);
    check("t_keep", core_T, t_m);
    check("k1_keep", core_K1 == {510{1'b1}}, 1);

    @(negedge clk); rst = 1'b0; #1;
    check("err_cleared", err, 0);
    check("k0_cleared", |core_K0, 0);
    @(negedge clk); rst = 1'b1;
    p_m = '0; t_m = '0;
    wr(6'd49, 32'h5A5A5A5A); wr(6'd54, 32'h01020304);

    launch(1'b1, 1, 0, lat);
    check("latency3", lat, L + 1);
    check("p_run_write", core_P, p_m);
    check("err_run", err, 1);
    drain(16'h1, 1);

    wr(6'd3, 32'h77777777);
    @(negedge clk); start = 1'b1; start_enc = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0; #1;
    check("mid_busy", busy, 0);
    check("mid_valid", out_valid, 0);
    check("mid_data", out_data, 0);
    check("mid_k0", |core_K0, 0);
    check("mid_err", err, 0);
    @(negedge clk); rst = 1'b1;
    p_m = '0; t_m = '0;

    launch(1'b1, 0, 1, lat);
    check("latency4", lat, L + 1);
    check("p_same_cycle", core_P, p_m);
    drain(16'b0110, 4);
    check("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
